// File: rtl/dcache_controller.sv
// Direct-mapped, write-back data cache controller.
// Handles CPU load/store hits with zero stall. On a miss it writes back a
// dirty victim line if needed, refills the line from memory, and then lets
// the CPU retry the access as a hit.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cpu_*                   CPU request (req/we/addr/data in), load data and stall out
//   sram_*_o                tag/data SRAM strobes, set index, write tag and line
//   sram_hit_i/tag_i/data_i SRAM lookup result: hit flag, stored tag, stored line
//   mem_*_o                 registered line request to memory (one-cycle enable pulse)
//   mem_ack_i, mem_data_i   one-cycle completion pulse and read line
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  input  logic         sram_hit_i,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  typedef enum logic [2:0] {
    StIdle,
    StMiss,
    StWriteback,
    StRefill,
    StRefillDone
  } state_e;

  state_e         state_q;
  logic           mem_enable_q;
  logic           mem_write_q;
  logic [31:0]    mem_addr_q;
  logic [255:0]   mem_data_q;

  logic [22:0]    tag;
  logic [3:0]     index;
  logic [7:0]     word_bit;
  logic           hit;
  logic [255:0]   merged_line;

  assign tag      = cpu_addr_i[31:9];
  assign index    = cpu_addr_i[8:5];
  assign word_bit = {cpu_addr_i[4:2], 5'b0};
  assign hit      = (state_q == StIdle) && sram_hit_i;

  assign sram_addr_o  = index;
  assign cpu_stall_o  = cpu_req_i && !hit;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_comb begin
    cpu_data_o  = sram_data_i[word_bit +: 32];
    merged_line = sram_data_i;
    merged_line[word_bit +: 32] = cpu_data_i;
  end

  // SRAM is written only on a store hit or when the refill line arrives.
  always_comb begin
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    if (cpu_req_i && cpu_we_i && hit) begin
      sram_enable_o = 1'b1;
      sram_write_o  = 1'b1;
      sram_tag_o    = {2'b11, tag};
      sram_data_o   = merged_line;
    end else if (state_q == StRefill && mem_ack_i) begin
      sram_enable_o = 1'b1;
      sram_write_o  = 1'b1;
      sram_tag_o    = {2'b10, tag};
      sram_data_o   = mem_data_i;
    end
  end

  // Memory request fields are registered and held until the next issue, so
  // they stay stable for the whole outstanding transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      mem_enable_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req_i && !sram_hit_i) state_q <= StMiss;
        end
        StMiss: begin
          if (sram_tag_i[24:23] == 2'b11) begin
            state_q      <= StWriteback;
            mem_enable_q <= 1'b1;
            mem_write_q  <= 1'b1;
            mem_addr_q   <= {sram_tag_i[22:0], index, 5'b0};
            mem_data_q   <= sram_data_i;
          end else begin
            state_q      <= StRefill;
            mem_enable_q <= 1'b1;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {tag, index, 5'b0};
          end
        end
        StWriteback: begin
          if (mem_ack_i) begin
            state_q      <= StRefill;
            mem_enable_q <= 1'b1;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {tag, index, 5'b0};
          end
        end
        StRefill: begin
          if (mem_ack_i) state_q <= StRefillDone;
        end
        StRefillDone: state_q <= StIdle;
        default:      state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hits, clean/dirty misses, request
// drop during writeback, and reset with a request outstanding.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         sram_enable;
  logic         sram_write;
  logic [3:0]   sram_addr;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_hit = 1'b0;
  logic [24:0]  sram_tag_i = '0;
  logic [255:0] sram_data_i = '0;
  logic         mem_enable;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_data_o;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_data_i = '0;

  int vectors = 0;
  int errors  = 0;
  int pulses  = 0;
  int p0;
  int stalls;
  logic [255:0] line;
  logic [255:0] exp_line;

  dcache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_wdata),
    .cpu_data_o   (cpu_rdata),
    .cpu_stall_o  (cpu_stall),
    .sram_enable_o(sram_enable),
    .sram_write_o (sram_write),
    .sram_addr_o  (sram_addr),
    .sram_tag_o   (sram_tag_o),
    .sram_data_o  (sram_data_o),
    .sram_hit_i   (sram_hit),
    .sram_tag_i   (sram_tag_i),
    .sram_data_i  (sram_data_i),
    .mem_enable_o (mem_enable),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_data_i)
  );

  always #5 clk = ~clk;

  // Registered request outputs are stable at the falling edge.
  always @(negedge clk) if (mem_enable === 1'b1) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data_o, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_sram_enable", sram_enable, 0);

    // Load hit: index 2, word 2
    line = mk_line(32'hA000_0000);
    line[64 +: 32] = 32'hDEAD_BEEF;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0048;
    sram_hit = 1; sram_tag_i = {2'b10, 23'h0}; sram_data_i = line;
    #1;
    chk("ld_data", cpu_rdata, 32'hDEAD_BEEF);
    chk("ld_stall", cpu_stall, 0);
    chk("ld_sram_addr", sram_addr, 4'd2);
    chk("ld_sram_enable", sram_enable, 0);

    // Store hit: index 2, word 1
    @(negedge clk);
    #1;
    chk("ld_no_mem", mem_enable, 0);
    cpu_we = 1; cpu_addr = 32'h0000_0044; cpu_wdata = 32'h1234_5678;
    exp_line = line;
    exp_line[32 +: 32] = 32'h1234_5678;
    #1;
    chk("st_sram_enable", sram_enable, 1);
    chk("st_sram_write", sram_write, 1);
    chk("st_sram_data", sram_data_o, exp_line);
    chk("st_sram_tag", sram_tag_o, {2'b11, 23'h0});
    chk("st_stall", cpu_stall, 0);

    // No request: no SRAM activity even with hit asserted
    @(negedge clk);
    cpu_req = 0;
    #1;
    chk("idle_sram_enable", sram_enable, 0);
    chk("st_no_mem", mem_enable, 0);

    // Clean miss: addr 0x220, victim invalid, 10 cycles in REFILL
    line = mk_line(32'hB000_0000);
    p0 = pulses;
    stalls = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0220;
    sram_hit = 0; sram_tag_i = '0; sram_data_i = '0;
    #1;
    stalls += int'(cpu_stall);
    chk("cm_stall", cpu_stall, 1);
    @(negedge clk);
    #1;
    stalls += int'(cpu_stall);
    chk("cm_miss_no_issue", mem_enable, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        mem_ack = 1; mem_data_i = line;
      end
      #1;
      stalls += int'(cpu_stall);
      if (k == 0) begin
        chk("cm_rd_enable", mem_enable, 1);
        chk("cm_rd_write", mem_write, 0);
        chk("cm_rd_addr", mem_addr, 32'h0000_0220);
      end
      if (k == 5) begin
        chk("cm_enable_pulse", mem_enable, 0);
        chk("cm_addr_held", mem_addr, 32'h0000_0220);
        chk("cm_wait_no_sram", sram_enable, 0);
      end
      if (k == 9) begin
        chk("cm_fill_write", sram_write, 1);
        chk("cm_fill_enable", sram_enable, 1);
        chk("cm_fill_tag", sram_tag_o, {2'b10, 23'h1});
        chk("cm_fill_data", sram_data_o, line);
      end
    end
    @(negedge clk);
    mem_ack = 0;
    #1;
    stalls += int'(cpu_stall);
    chk("cm_done_stall", cpu_stall, 1);
    chk("cm_done_no_sram", sram_enable, 0);
    @(negedge clk);
    sram_hit = 1; sram_tag_i = {2'b10, 23'h1}; sram_data_i = line;
    #1;
    stalls += int'(cpu_stall);
    chk("cm_retry_stall", cpu_stall, 0);
    chk("cm_retry_data", cpu_rdata, 32'hB000_0000);
    chk("cm_stall_cycles", stalls, 13);
    chk("cm_pulses", pulses - p0, 1);

    // Dirty miss: addr 0x460 (tag 2, index 3), victim {1,1,5}
    exp_line = mk_line(32'hC000_0000);
    line = mk_line(32'hD000_0000);
    p0 = pulses;
    @(negedge clk);
    cpu_addr = 32'h0000_0460; sram_hit = 0;
    sram_tag_i = {2'b11, 23'h5}; sram_data_i = exp_line;
    #1;
    chk("dm_stall", cpu_stall, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("dm_wb_enable", mem_enable, 1);
    chk("dm_wb_write", mem_write, 1);
    chk("dm_wb_addr", mem_addr, 32'h0000_0A60);
    chk("dm_wb_data", mem_data_o, exp_line);
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1;
    #1;
    chk("dm_wb_ack_no_sram", sram_write, 0);
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("dm_rd_enable", mem_enable, 1);
    chk("dm_rd_write", mem_write, 0);
    chk("dm_rd_addr", mem_addr, 32'h0000_0460);
    @(negedge clk);
    mem_ack = 1; mem_data_i = line;
    #1;
    chk("dm_fill_write", sram_write, 1);
    chk("dm_fill_tag", sram_tag_o, {2'b10, 23'h2});
    chk("dm_fill_data", sram_data_o, line);
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("dm_done_stall", cpu_stall, 1);
    @(negedge clk);
    sram_hit = 1; sram_tag_i = {2'b10, 23'h2}; sram_data_i = line;
    #1;
    chk("dm_retry_stall", cpu_stall, 0);
    chk("dm_pulses", pulses - p0, 2);

    // Dirty miss with the request dropped during writeback
    p0 = pulses;
    @(negedge clk);
    sram_hit = 0; sram_tag_i = {2'b11, 23'h5}; sram_data_i = exp_line;
    @(negedge clk);
    @(negedge clk);
    cpu_req = 0;
    #1;
    chk("dr_no_stall", cpu_stall, 0);
    @(negedge clk);
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    @(negedge clk);
    mem_ack = 1; mem_data_i = line;
    #1;
    chk("dr_fill_write", sram_write, 1);
    @(negedge clk);
    mem_ack = 0;
    @(negedge clk);
    cpu_req = 1; sram_hit = 1; sram_data_i = line;
    #1;
    chk("dr_idle_hit", cpu_stall, 0);
    chk("dr_pulses", pulses - p0, 2);

    // Reset while in REFILL, then a stray ack
    @(negedge clk);
    cpu_addr = 32'h0000_0220; sram_hit = 0; sram_tag_i = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rr_rd_enable", mem_enable, 1);
    @(negedge clk);
    rst = 1; cpu_req = 0;
    @(negedge clk);
    rst = 0; mem_ack = 1; mem_data_i = line;
    p0 = pulses;
    #1;
    chk("rr_no_sram_write", sram_write, 0);
    chk("rr_mem_enable", mem_enable, 0);
    chk("rr_mem_addr", mem_addr, 0);
    @(negedge clk);
    mem_ack = 0;
    cpu_req = 1; sram_hit = 1;
    #1;
    chk("rr_idle_hit", cpu_stall, 0);
    chk("rr_no_pulse", pulses - p0, 0);
    @(negedge clk);
    cpu_req = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 cpu_req_i  in  1  CPU data access request; held with address and data stable while cpu_stall_o=1.
REQ-005 cpu_we_i  in  1  1=store word, 0=load word.
REQ-006 cpu_addr_i  in  32  byte address: tag=[31:9], index=[8:5], word=[4:2].
REQ-007 cpu_data_i  in  32  store data.
REQ-008 cpu_data_o  out  32  load data.
REQ-009 cpu_stall_o  out  1  CPU must hold the request.
REQ-010 sram_enable_o, sram_write_o  out  1 each  SRAM access and write strobes.
REQ-011 sram_addr_o  out  4  set index; sram_tag_o  out  25  {valid, dirty, tag[22:0]}; sram_data_o  out  256  line data.
REQ-012 sram_hit_i  in  1; sram_tag_i  in  25; sram_data_i  in  256  hit flag, plus hit line or victim line when missing.
REQ-013 mem_enable_o  out  1  one-cycle request pulse; mem_write_o  out  1; mem_addr_o  out  32; mem_data_o  out  256.
REQ-014 mem_ack_i  in  1  one-cycle completion pulse; mem_data_i  in  256  read line, valid with ack.

Function
REQ-015 sram_addr_o SHALL equal cpu_addr_i[8:5] in all states.
REQ-016 FSM states SHALL be IDLE, MISS, WRITEBACK, REFILL and REFILL_DONE.
REQ-017 IDLE with cpu_req_i=1 and sram_hit_i=1 SHALL be a hit:
  - Latency: zero stall cycles; cpu_stall_o=0 that cycle.
  - cpu_data_o = sram_data_i[32w+31:32w], where w = cpu_addr_i[4:2].
REQ-018 A store hit SHALL assert sram_enable_o=1 and sram_write_o=1 in the same cycle:
  - sram_data_o = sram_data_i with word w replaced by cpu_data_i.
  - sram_tag_o = {1,1,cpu_addr_i[31:9]}.
REQ-019 IDLE with cpu_req_i=1 and sram_hit_i=0 SHALL go to MISS with cpu_stall_o=1.
REQ-020 cpu_stall_o SHALL equal cpu_req_i AND NOT (state==IDLE AND sram_hit_i).
REQ-021 MISS, victim sram_tag_i[24:23]==2'b11 (valid and dirty): go to WRITEBACK and issue a write for one cycle:
  - mem_enable_o=1, mem_write_o=1;
  - mem_addr_o = {sram_tag_i[22:0], index, 5'b0};
  - mem_data_o = sram_data_i.
REQ-022 MISS, victim not both valid and dirty: go to REFILL and issue a read: mem_enable_o=1, mem_write_o=0, mem_addr_o = {cpu_addr_i[31:9], index, 5'b0}.
REQ-023 mem_addr_o, mem_write_o and mem_data_o SHALL be registered and held stable from issue until mem_ack_i.
REQ-024 mem_enable_o SHALL be high for exactly one cycle per request.
REQ-025 WRITEBACK SHALL wait for mem_ack_i, then issue the refill read (as REQ-022) and go to REFILL.
REQ-026 REFILL SHALL wait for mem_ack_i, then in that cycle:
  - assert sram_enable_o=1, sram_write_o=1;
  - drive sram_data_o = mem_data_i and sram_tag_o = {1,0,cpu_addr_i[31:9]};
  - go to REFILL_DONE.
REQ-027 REFILL_DONE SHALL go to IDLE unconditionally; the retried access then hits per REQ-017/018.
REQ-028 Outside REQ-018 and REQ-026, sram_enable_o and sram_write_o SHALL be 0.
REQ-029 mem_ack_i SHALL be ignored in IDLE, MISS and REFILL_DONE.
REQ-030 A miss, once entered, SHALL complete its refill even if cpu_req_i drops.
REQ-031 cpu_req_i=0 in IDLE SHALL cause no SRAM or memory activity.
REQ-032 Miss penalty: clean miss = 3 cycles + memory latency; dirty miss = 3 cycles + two memory latencies.

Reset
REQ-033 rst_i=1 at a clock edge SHALL force state IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0 and mem_data_o=0.
REQ-034 Reset SHALL take effect in any state, including WRITEBACK or REFILL with a request outstanding; a later mem_ack_i SHALL then be ignored.
REQ-035 The combinational outputs SHALL follow their equations from the first post-reset cycle; cpu_data_o reset value is don't-care.

Verification
REQ-036 Load hit: addr 0x0000_0048, SRAM hit, line word 2 = 0xDEADBEEF -> cpu_data_o=0xDEADBEEF, cpu_stall_o=0, no memory request.
REQ-037 Store hit: addr 0x0000_0044, data 0x12345678 -> one SRAM write, word 1 replaced, tag dirty=1, zero stall.
REQ-038 Clean miss: addr 0x0000_0220, victim invalid, ack after 10 cycles:
  - one read at 0x0000_0220;
  - refill tag {1,0,23'h1};
  - hit in IDLE; stall 13 cycles.
REQ-039 Dirty miss: victim tag {1,1,23'h5}, index 3:
  - write at 0x0000_0A60 carrying the victim data;
  - then read at the CPU line address;
  - exactly two mem_enable_o pulses.
REQ-040 Reset in REFILL, then a stray mem_ack_i -> state IDLE, no SRAM write, mem_enable_o stays 0.
REQ-041 cpu_req_i drops while in WRITEBACK -> writeback and refill still complete, then IDLE.
